// File: rtl/trace_capture.sv
// trace_capture: passive retirement-trace collector for single_period_cpu.
// Captures each new (pc, inst) pair into an on-chip FIFO, detects program halt
// (branch-to-self, pc unchanged for HALT_REPEAT cycles) and exposes the trace on
// a valid/ready read port.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      arms capture (honoured only in IDLE)
//   pc, inst   CPU program counter / instruction
//   rd_valid   FIFO non-empty
//   rd_ready   consumer accepts head entry
//   rd_pc      head entry pc (registered)
//   rd_inst    head entry instruction (registered)
//   count      FIFO occupancy
//   capturing  in CAPTURE state
//   halted     in HALTED state
//   overflow   sticky: a sample was dropped on a full FIFO
//   checksum   rolling checksum of accepted pushes (only with TRACE_CHECKSUM_EN)
//
// Optional feature macro: TRACE_CHECKSUM_EN
module trace_capture #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [INSTR_W-1:0]         inst,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [INSTR_W-1:0]         rd_inst,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       capturing,
    output logic                       halted,
    output logic                       overflow
`ifdef TRACE_CHECKSUM_EN
    ,
    output logic [31:0]                checksum
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned REP_W = $clog2(HALT_REPEAT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    last_pc_q;
    logic                 first_q;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [ADDR_W-1:0]    mem_pc   [DEPTH];
    logic [INSTR_W-1:0]   mem_inst [DEPTH];

    logic                 sample, pop, full, push, drop, halt_hit;
    logic [CNT_W-1:0]     remain, count_d;
    logic [ADDR_W-1:0]    head_pc_d;
    logic [INSTR_W-1:0]   head_inst_d;
    logic                 capturing_d, halted_d;

    // Sample qualification and FIFO handshake decisions
    always_comb begin : control_logic
        sample   = 1'b0;
        pop      = 1'b0;
        full     = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        halt_hit = 1'b0;
        sample   = (state_q == CAPTURE) && (first_q || (pc != last_pc_q));
        pop      = rd_valid && rd_ready;
        full     = (count == CNT_W'(DEPTH));
        // A pop in the same cycle frees the slot for a sample arriving at full
        push     = sample && (!full || pop);
        drop     = sample && full && !pop;
        // Counter is about to reach HALT_REPEAT-1 on this non-qualifying sample
        halt_hit = (state_q == CAPTURE) && !sample
                   && (rep_q == REP_W'(HALT_REPEAT - 2));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state_logic
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = CAPTURE;
            CAPTURE: if (halt_hit) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Next values of registered outputs, pointers and head entry
    always_comb begin : output_logic
        capturing_d = (state_d == CAPTURE);
        halted_d    = (state_d == HALTED);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        remain      = count - CNT_W'(pop);
        count_d     = remain + CNT_W'(push);
        rep_d       = rep_q;
        if (sample) begin
            rep_d = '0;
        end else if (state_q == CAPTURE) begin
            rep_d = rep_q + REP_W'(1);
        end
        // Head bypasses storage when the pushed entry becomes the head directly
        if (count_d == '0) begin
            head_pc_d   = '0;
            head_inst_d = '0;
        end else if (push && (remain == '0)) begin
            head_pc_d   = pc;
            head_inst_d = inst;
        end else begin
            head_pc_d   = mem_pc[rd_ptr_d];
            head_inst_d = mem_inst[rd_ptr_d];
        end
    end

    // FIFO storage (no reset needed; validity is tracked by count)
    always_ff @(posedge clk) begin : fifo_mem
        if (push) begin
            mem_pc[wr_ptr_q]   <= pc;
            mem_inst[wr_ptr_q] <= inst;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin : datapath_regs
        if (!rst) begin
            last_pc_q <= '0;
            first_q   <= 1'b1;
            rep_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_pc     <= '0;
            rd_inst   <= '0;
            capturing <= 1'b0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // Dropped samples still advance last_pc
            if (sample) begin
                last_pc_q <= pc;
                first_q   <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            rep_q     <= rep_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count     <= count_d;
            rd_valid  <= (count_d != '0);
            rd_pc     <= head_pc_d;
            rd_inst   <= head_inst_d;
            capturing <= capturing_d;
            halted    <= halted_d;
        end
    end

`ifdef TRACE_CHECKSUM_EN
    // Rolling checksum over accepted pushes; frozen once no pushes occur
    always_ff @(posedge clk or negedge rst) begin : checksum_reg
        if (!rst) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= {checksum[30:0], checksum[31]} ^ 32'(inst) ^ 32'(pc);
        end
    end
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed scenarios plus randomized
// episodes, checked against a queue-based reference model of the trace rules.
module tb_trace_capture;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned HALT_REPEAT = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] pc       = '0;
    logic [31:0] inst     = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [4:0]  count;
    logic        capturing;
    logic        halted;
    logic        overflow;
`ifdef TRACE_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    trace_capture #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .DEPTH      (DEPTH),
        .HALT_REPEAT(HALT_REPEAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pc       (pc),
        .inst     (inst),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_inst  (rd_inst),
        .count    (count),
        .capturing(capturing),
        .halted   (halted),
        .overflow (overflow)
`ifdef TRACE_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: trace as a queue, plus a few mode flags
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    bit          m_cap, m_halt, m_ovf, m_first;
    logic [31:0] m_last;
    int          m_rep;
    logic [31:0] m_ck;
    logic [31:0] popped[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_inst.delete();
        m_cap   = 1'b0;
        m_halt  = 1'b0;
        m_ovf   = 1'b0;
        m_first = 1'b1;
        m_last  = '0;
        m_rep   = 0;
        m_ck    = '0;
    endtask

    // One rising edge of the trace rules, using the inputs presented before it
    task automatic model_edge();
        bit pop_ok, smp;
        logic [31:0] dmy;
        pop_ok = (mq_pc.size() != 0) && rd_ready;
        smp    = m_cap && (m_first || (pc != m_last));
        if (pop_ok) begin
            dmy = mq_pc.pop_front();
            dmy = mq_inst.pop_front();
        end
        if (smp) begin
            if (mq_pc.size() < DEPTH) begin
                mq_pc.push_back(pc);
                mq_inst.push_back(inst);
                m_ck = {m_ck[30:0], m_ck[31]} ^ inst ^ pc;
            end else begin
                m_ovf = 1'b1;
            end
            m_last  = pc;
            m_first = 1'b0;
            m_rep   = 0;
        end else if (m_cap) begin
            m_rep++;
            if (m_rep == HALT_REPEAT - 1) begin
                m_cap  = 1'b0;
                m_halt = 1'b1;
            end
        end else if (!m_halt && start) begin
            m_cap = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("rd_valid",  64'(rd_valid),  64'(mq_pc.size() != 0));
        chk("count",     64'(count),     64'(mq_pc.size()));
        chk("capturing", 64'(capturing), 64'(m_cap));
        chk("halted",    64'(halted),    64'(m_halt));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        if (mq_pc.size() != 0) begin
            chk("rd_pc",   64'(rd_pc),   64'(mq_pc[0]));
            chk("rd_inst", 64'(rd_inst), 64'(mq_inst[0]));
        end
`ifdef TRACE_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(m_ck));
`endif
    endtask

    // Drive inputs after a falling edge, clock once, check at the falling edge
    task automatic step(input bit s, input logic [31:0] p, input logic [31:0] i, input bit rr);
        start    = s;
        pc       = p;
        inst     = i;
        rd_ready = rr;
        #1;
        if (rd_valid && rd_ready) popped.push_back(rd_pc);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted mid-cycle for 5 ns; outputs must clear without a clock
    task automatic async_reset_check();
        start    = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_rd_valid",  64'(rd_valid),  64'(0));
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_rd_pc",     64'(rd_pc),     64'(0));
        chk("rst_rd_inst",   64'(rd_inst),   64'(0));
        chk("rst_capturing", 64'(capturing), 64'(0));
        chk("rst_halted",    64'(halted),    64'(0));
        chk("rst_overflow",  64'(overflow),  64'(0));
        #4 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rp;
        int          rr_pct;

        // Power-on reset
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;
        @(negedge clk);

        // Linear fetch capture
        step(1'b1, 32'h0,  32'h0,        1'b0);
        step(1'b0, 32'h00, 32'h20080005, 1'b0);
        step(1'b0, 32'h04, 32'h20090003, 1'b0);
        step(1'b0, 32'h08, 32'h01095020, 1'b0);
        chk("lin_count",     64'(count),     64'(3));
        chk("lin_rd_pc",     64'(rd_pc),     64'(32'h0));
        chk("lin_rd_inst",   64'(rd_inst),   64'(32'h20080005));
        chk("lin_capturing", 64'(capturing), 64'(1));

        // Drain while the CPU sits on a branch-to-self at 0x0C
        popped.delete();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0C, 32'h08000003, 1'b1);
            chk("halt_edge", 64'(halted), 64'(k == 3));
        end
        chk("drain_rd_valid", 64'(rd_valid), 64'(0));
        chk("drain_n", 64'(popped.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", 64'(popped[k]), 64'(32'(k * 4)));
        end
        // Halted is terminal: pc changes and start ignored
        step(1'b0, 32'h10, 32'h11111111, 1'b1);
        step(1'b1, 32'h14, 32'h22222222, 1'b1);
        step(1'b0, 32'h18, 32'h33333333, 1'b1);
        chk("halt_hold_count",  64'(count),  64'(0));
        chk("halt_hold_halted", 64'(halted), 64'(1));

        // Reset with three entries held, then start is required again
        async_reset_check();
        step(1'b1, 32'h0,   32'h0,        1'b0);
        step(1'b0, 32'h200, 32'hAAAA0001, 1'b0);
        step(1'b0, 32'h204, 32'hAAAA0002, 1'b0);
        step(1'b0, 32'h208, 32'hAAAA0003, 1'b0);
        chk("pre_rst_count", 64'(count), 64'(3));
        async_reset_check();
        step(1'b0, 32'h300, 32'h1, 1'b0);
        step(1'b0, 32'h304, 32'h2, 1'b0);
        chk("norestart_cap",   64'(capturing), 64'(0));
        chk("norestart_count", 64'(count),     64'(0));

        // Overflow: 18 distinct pcs into a 16-deep FIFO with no reads
        step(1'b1, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 32'(k * 4), $urandom, 1'b0);
        end
        chk("ovf_count", 64'(count),    64'(16));
        chk("ovf_flag",  64'(overflow), 64'(1));
        popped.delete();
        for (int k = 0; k < 17; k++) begin
            step(1'b0, 32'h44, 32'h0, 1'b1);
        end
        chk("ovf_drain_n", 64'(popped.size()), 64'(16));
        for (int k = 0; k < 16; k++) begin
            chk("ovf_order", 64'(popped[k]), 64'(32'(k * 4)));
        end

        // Full FIFO with a pop every cycle accepts pushes without overflow
        async_reset_check();
        step(1'b1, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 32'h100 + 32'(k * 4), $urandom, 1'b0);
        end
        chk("full_count", 64'(count), 64'(16));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h200 + 32'(k * 4), $urandom, 1'b1);
            chk("full_rw_count", 64'(count),    64'(16));
            chk("full_rw_ovf",   64'(overflow), 64'(0));
        end

        // Randomized episodes against the model
        for (int e = 0; e < 6; e++) begin
            async_reset_check();
            rr_pct = 20 + e * 15;
            rp     = '0;
            for (int n = 0; n < 90; n++) begin
                if ($urandom_range(0, 9) >= 3) rp = $urandom & 32'hFFFF_FFFC;
                step(($urandom_range(0, 7) == 0), rp, $urandom,
                     ($urandom_range(0, 99) < rr_pct));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
